// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
//
// Single-clock first-in/first-out buffer with registered read data and
// registered status flags.
//
// Parameters
//   DATA_W  : data word width in bits
//   DEPTH   : number of entries (power of two, at least 4)
//   UPP_TH  : almost-full margin, in free entries
//   LOW_TH  : almost-empty level, in occupied entries
//
// Ports
//   clk          in   1       single clock, all state updates on rising edge
//   reset        in   1       asynchronous active-high reset
//   i_wrdata     in   DATA_W  write data
//   i_wren       in   1       write request
//   i_rden       in   1       read request
//   o_rddata     out  DATA_W  read data, valid the cycle after an accepted read
//   o_full       out  1       FIFO holds DEPTH entries
//   o_empty      out  1       FIFO holds 0 entries
//   o_alm_full   out  1       count >= DEPTH-UPP_TH
//   o_alm_empty  out  1       count <= LOW_TH
//
// Request/accept rules (there is no back-pressure handshake beyond the flags):
//   - A read is accepted on an edge where i_rden=1 and o_empty=0. The word at
//     the read pointer is loaded into o_rddata on that same edge, so it is
//     visible in the following cycle and held until the next accepted read.
//   - A write is accepted on an edge where i_wren=1 and either o_full=0 or a
//     read is accepted on the same edge. Requests that are not accepted are
//     dropped without any state change.
//   - While reset=1 every request is ignored.
// -----------------------------------------------------------------------------
module sync_fifo #(
    parameter int DATA_W = 128,
    parameter int DEPTH  = 1024,
    parameter int UPP_TH = 4,
    parameter int LOW_TH = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] i_wrdata,
    input  logic              i_wren,
    input  logic              i_rden,
    output logic [DATA_W-1:0] o_rddata,
    output logic              o_full,
    output logic              o_empty,
    output logic              o_alm_full,
    output logic              o_alm_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // Count thresholds, sized to the count register so comparisons are
    // width-matched.
    localparam logic [CW-1:0] FULL_LVL      = CW'(DEPTH);
    localparam logic [CW-1:0] ALM_FULL_LVL  = CW'(DEPTH - UPP_TH);
    localparam logic [CW-1:0] ALM_EMPTY_LVL = CW'(LOW_TH);

    // Storage: no reset, contents are only meaningful between the pointers.
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q,  count_d;
    logic [DATA_W-1:0] rddata_q;
    logic              full_q,   full_d;
    logic              empty_q,  empty_d;
    logic              alm_full_q,  alm_full_d;
    logic              alm_empty_q, alm_empty_d;

    logic rd_accept;
    logic wr_accept;

    // A read frees a slot on the same edge, so a full FIFO can still take a
    // write when it is also being read. An empty FIFO never accepts a read,
    // which makes a simultaneous write/read on empty a plain write (no
    // fall-through).
    assign rd_accept = i_rden & ~empty_q;
    assign wr_accept = i_wren & (~full_q | rd_accept);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        // Pointers wrap naturally because DEPTH is a power of two.
        if (wr_accept) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (rd_accept) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        case ({wr_accept, rd_accept})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Flags come from the next-state count so that, once registered, they
    // describe the same count that is held in count_q.
    always_comb begin
        full_d      = (count_d == FULL_LVL);
        empty_d     = (count_d == '0);
        alm_full_d  = (count_d >= ALM_FULL_LVL);
        alm_empty_d = (count_d <= ALM_EMPTY_LVL);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            rddata_q    <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            alm_full_q  <= 1'b0;
            alm_empty_q <= 1'b1;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            full_q      <= full_d;
            empty_q     <= empty_d;
            alm_full_q  <= alm_full_d;
            alm_empty_q <= alm_empty_d;
            // On a simultaneous read/write when full both pointers address the
            // same slot; the read here samples the old word before the write
            // below replaces it, so the oldest entry is what comes out.
            if (rd_accept) begin
                rddata_q <= mem_q[rd_ptr_q];
            end
        end
    end

    // The memory has no reset, so the write is explicitly blocked while
    // reset is high to keep requests on reset edges fully ignored.
    always_ff @(posedge clk) begin
        if (wr_accept && !reset) begin
            mem_q[wr_ptr_q] <= i_wrdata;
        end
    end

    assign o_rddata    = rddata_q;
    assign o_full      = full_q;
    assign o_empty     = empty_q;
    assign o_alm_full  = alm_full_q;
    assign o_alm_empty = alm_empty_q;

endmodule

// File: tb/tb_sync_fifo.sv
// -----------------------------------------------------------------------------
// tb_sync_fifo
//
// Self-checking bench for sync_fifo (DEPTH=16, DATA_W=128, UPP_TH=4,
// LOW_TH=2). The reference is a queue of words plus the last value read out;
// every cycle the bench applies the FIFO rules to the queue and compares all
// outputs one time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_sync_fifo;

    localparam int DW    = 128;
    localparam int DEPTH = 16;
    localparam int UPP   = 4;
    localparam int LOW   = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic [DW-1:0] i_wrdata;
    logic          i_wren;
    logic          i_rden;
    logic [DW-1:0] o_rddata;
    logic          o_full;
    logic          o_empty;
    logic          o_alm_full;
    logic          o_alm_empty;

    sync_fifo #(
        .DATA_W (DW),
        .DEPTH  (DEPTH),
        .UPP_TH (UPP),
        .LOW_TH (LOW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .i_wrdata    (i_wrdata),
        .i_wren      (i_wren),
        .i_rden      (i_rden),
        .o_rddata    (o_rddata),
        .o_full      (o_full),
        .o_empty     (o_empty),
        .o_alm_full  (o_alm_full),
        .o_alm_empty (o_alm_empty)
    );

    // ---------------- scoreboard ----------------
    int            n_checks = 0;
    int            n_errors = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] exp_rd;

    task automatic check_val(input string tag, input logic [DW-1:0] obs,
                             input logic [DW-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        int n;
        n = exp_q.size();
        check_val({tag, ".rddata"},    o_rddata,         exp_rd);
        check_val({tag, ".full"},      DW'(o_full),      DW'(n == DEPTH));
        check_val({tag, ".empty"},     DW'(o_empty),     DW'(n == 0));
        check_val({tag, ".alm_full"},  DW'(o_alm_full),  DW'(n >= DEPTH - UPP));
        check_val({tag, ".alm_empty"}, DW'(o_alm_empty), DW'(n <= LOW));
    endtask

    function automatic logic [DW-1:0] rand_word();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // ---------------- driver tasks ----------------
    // One clock cycle with the given requests; the model is advanced at the
    // edge and outputs are compared 1 time unit later.
    task automatic cycle(input string tag, input logic we, input logic re,
                         input logic [DW-1:0] d);
        bit rd_acc;
        bit wr_acc;
        i_wren   = we;
        i_rden   = re;
        i_wrdata = d;
        @(posedge clk);
        rd_acc = re && (exp_q.size() > 0);
        wr_acc = we && ((exp_q.size() < DEPTH) || rd_acc);
        if (rd_acc) exp_rd = exp_q.pop_front();
        if (wr_acc) exp_q.push_back(d);
        #1;
        i_wren = 1'b0;
        i_rden = 1'b0;
        check_outputs(tag);
    endtask

    task automatic wr(input string tag, input logic [DW-1:0] d);
        cycle(tag, 1'b1, 1'b0, d);
    endtask

    task automatic rd(input string tag);
        cycle(tag, 1'b0, 1'b1, '0);
    endtask

    task automatic drain(input string tag);
        for (int k = 0; k < 2 * DEPTH && exp_q.size() > 0; k++) rd(tag);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset    = 1'b1;
        i_wren   = 1'b0;
        i_rden   = 1'b0;
        i_wrdata = '0;
        exp_rd   = '0;

        // Power-on reset held across an edge.
        #12;
        check_outputs("reset");
        #1 reset = 1'b0;

        // Three writes then three reads.
        wr("w3", DW'(1));
        wr("w3", DW'(2));
        wr("w3", DW'(3));
        rd("r3");
        check_val("r3.first", o_rddata, DW'(1));
        rd("r3");
        rd("r3");
        check_val("r3.last", o_rddata, DW'(3));

        // Fill to full, overflow write is dropped, drain in order.
        for (int i = 0; i < DEPTH; i++) wr("fill", rand_word());
        wr("ovf", DW'(32'hDEAD));
        check_val("ovf.qsize", DW'(exp_q.size()), DW'(DEPTH));
        drain("drain16");

        // Read on empty: output holds, still empty.
        rd("rd_empty");
        rd("rd_empty");

        // Simultaneous write/read when full, then when empty.
        for (int i = 0; i < DEPTH; i++) wr("fill2", rand_word());
        cycle("both_full", 1'b1, 1'b1, rand_word());
        cycle("both_full", 1'b1, 1'b1, rand_word());
        drain("drain2");
        cycle("both_empty", 1'b1, 1'b1, rand_word());
        rd("both_empty_rd");

        // 40 write/read pairs; pointers wrap several times.
        for (int i = 0; i < 40; i++) begin
            wr("pair_w", rand_word());
            rd("pair_r");
        end

        // Random traffic with shifting write bias to sweep all fill levels.
        for (int i = 0; i < 400; i++) begin
            int wp;
            wp = ((i / 50) % 2 == 0) ? 75 : 25;
            cycle("rand", ($urandom_range(0, 99) < wp), ($urandom_range(0, 99) < 100 - wp),
                  rand_word());
        end

        // Asynchronous reset mid-cycle at count 9.
        drain("pre_rst");
        for (int i = 0; i < 9; i++) wr("to9", rand_word());
        rd("to9_rd");
        wr("to9", rand_word());
        check_val("to9.qsize", DW'(exp_q.size()), DW'(9));
        #2 reset = 1'b1;
        exp_q.delete();
        exp_rd = '0;
        #1;
        check_outputs("async_rst");
        // Requests on an edge with reset high are ignored.
        i_wren   = 1'b1;
        i_rden   = 1'b1;
        i_wrdata = rand_word();
        @(posedge clk);
        #1;
        i_wren = 1'b0;
        i_rden = 1'b0;
        check_outputs("rst_edge");
        #2 reset = 1'b0;
        // No stale data after release.
        rd("post_rst_rd");
        wr("post_rst_w", DW'(32'h55));
        rd("post_rst_r");
        check_val("post_rst.data", o_rddata, DW'(32'h55));

        // ---------------- report ----------------
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
